// File: rtl/wb_mem_pkg.sv
// Shared types and helpers for the parametrised Wishbone memory slave.
package wb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } wb_mem_state_t;

    localparam int WAIT_CNT_W = 4;

    // Replace the bytes of old_word selected by be with the matching bytes of new_word.
    // Operands are widened to 64 bits so one helper serves every legal data width.
    function automatic logic [63:0] byte_merge(
        input logic [63:0] old_word,
        input logic [63:0] new_word,
        input logic [7:0]  be
    );
        logic [63:0] res;
        res = old_word;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_mem_array.sv
// Byte-enabled DEPTH x DATA_W storage with asynchronous-reset initialisation
// and a combinational read port.
module wb_mem_array
    import wb_mem_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         ADDR_W    = 8,
    parameter int         DEPTH     = 256,
    parameter logic [7:0] INIT_BYTE = 8'h11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   rdata
);

    localparam int              NB       = DATA_W / 8;
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_merged;
    logic              w_wr_ok;
    logic              w_rd_ok;

    // Addresses beyond the implemented depth never touch storage.
    assign w_wr_ok  = wr_en && ({1'b0, waddr} < LP_DEPTH);
    assign w_rd_ok  = ({1'b0, raddr} < LP_DEPTH);
    assign w_merged = DATA_W'(byte_merge(64'(r_mem[waddr]), 64'(wdata), 8'(be)));
    assign rdata    = w_rd_ok ? r_mem[raddr] : '0;

    // Byte-enabled write port; reset fills every byte with INIT_BYTE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {NB{INIT_BYTE}};
            end
        end else if (w_wr_ok) begin
            r_mem[waddr] <= w_merged;
        end
    end

endmodule

// File: rtl/mem_wb_param.sv
// Parametrised Wishbone-classic memory slave: request latch, wait-state FSM,
// range check and registered ack/err/rdata around a byte-enabled RAM.
module mem_wb_param
    import wb_mem_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         ADDR_W    = 8,
    parameter int         DEPTH     = 256,
    parameter int         WAIT_CYC  = 0,
    parameter logic [7:0] INIT_BYTE = 8'h11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cyc,
    input  logic                stb,
    input  logic                we,
    input  logic [DATA_W/8-1:0] sel,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                ack,
    output logic                err
);

    if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_data_w
        $error("mem_wb_param: DATA_W must be a multiple of 8 in 8..64");
    end
    if (DEPTH > (2 ** ADDR_W) || DEPTH < 1) begin : g_bad_depth
        $error("mem_wb_param: DEPTH must be 1..2**ADDR_W");
    end
    if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait
        $error("mem_wb_param: WAIT_CYC must be 0..15");
    end

    localparam logic [ADDR_W:0]     LP_DEPTH     = (ADDR_W + 1)'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] LP_WAIT_INIT =
        WAIT_CNT_W'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);

    wb_mem_state_t         r_state;
    wb_mem_state_t         w_next;
    logic [WAIT_CNT_W-1:0] r_cnt;

    logic                  r_we;
    logic [DATA_W/8-1:0]   r_sel;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;

    logic                  r_ack;
    logic                  r_err;
    logic [DATA_W-1:0]     r_rdata;

    logic                  w_req;
    logic                  w_cur_we;
    logic [DATA_W/8-1:0]   w_cur_sel;
    logic [ADDR_W-1:0]     w_cur_addr;
    logic [DATA_W-1:0]     w_cur_wdata;
    logic                  w_oor;
    logic                  w_fire;
    logic                  w_mem_wr;
    logic [DATA_W-1:0]     w_mem_rdata;

    assign w_req = cyc && stb;

    // With zero wait states the transfer terminates on the same edge that
    // samples the request, so the live bus is used while still in IDLE.
    assign w_cur_we    = (r_state == IDLE) ? we    : r_we;
    assign w_cur_sel   = (r_state == IDLE) ? sel   : r_sel;
    assign w_cur_addr  = (r_state == IDLE) ? addr  : r_addr;
    assign w_cur_wdata = (r_state == IDLE) ? wdata : r_wdata;

    assign w_oor    = ({1'b0, w_cur_addr} >= LP_DEPTH);
    assign w_fire   = (w_next == RESP);
    assign w_mem_wr = w_fire && w_cur_we && !w_oor;

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign err   = r_err;

    wb_mem_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .INIT_BYTE (INIT_BYTE)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (w_mem_wr),
        .be    (w_cur_sel),
        .waddr (w_cur_addr),
        .wdata (w_cur_wdata),
        .raddr (w_cur_addr),
        .rdata (w_mem_rdata)
    );

    // Next-state logic; dropping cyc during wait states aborts the transfer.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next = (WAIT_CYC == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!cyc) begin
                    w_next = IDLE;
                end else if (r_cnt == '0) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = GAP;
            GAP:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register and wait-state down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_cnt <= LP_WAIT_INIT;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - WAIT_CNT_W'(1);
            end
        end
    end

    // Capture the request so later bus changes cannot disturb the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE && w_req) begin
            r_we    <= we;
            r_sel   <= sel;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    // Registered termination and read data; rdata holds outside read/err responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_fire && !w_oor;
            r_err <= w_fire && w_oor;
            if (w_fire) begin
                if (w_oor) begin
                    r_rdata <= '0;
                end else if (!w_cur_we) begin
                    r_rdata <= w_mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_param.sv
// Directed, table-driven bench for mem_wb_param: three instances cover
// zero wait states with a short depth, and three and five wait states.
module tb_mem_wb_param;

    logic        clk;
    logic        rst_n;
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [3:0]  sel   [3];
    logic [7:0]  addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];

    int total;
    int bad;

    typedef struct {
        int          idx;
        logic        w;
        logic [3:0]  s;
        logic [7:0]  a;
        logic [31:0] d;
        logic        expAck;
        logic        expErr;
        logic        chkData;
        logic [31:0] expData;
        int          expLat;
    } vec_t;

    // idx 0: WAIT_CYC=0, DEPTH=200
    mem_wb_param #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WAIT_CYC(0), .INIT_BYTE(8'h11)) dut0 (
        .clk(clk), .rst_n(rst_n), .cyc(cyc[0]), .stb(stb[0]), .we(we[0]), .sel(sel[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0])
    );

    // idx 1: WAIT_CYC=3, DEPTH=256
    mem_wb_param #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(3), .INIT_BYTE(8'h11)) dut1 (
        .clk(clk), .rst_n(rst_n), .cyc(cyc[1]), .stb(stb[1]), .we(we[1]), .sel(sel[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1])
    );

    // idx 2: WAIT_CYC=5, DEPTH=256
    mem_wb_param #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(5), .INIT_BYTE(8'h11)) dut2 (
        .clk(clk), .rst_n(rst_n), .cyc(cyc[2]), .stb(stb[2]), .we(we[2]), .sel(sel[2]),
        .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .err(err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input int idx, input logic w, input logic [3:0] s,
                                   input logic [7:0] a, input logic [31:0] d,
                                   input logic eAck, input logic eErr, input logic cData,
                                   input logic [31:0] eData, input int eLat);
        vec_t v;
        v.idx = idx; v.w = w; v.s = s; v.a = a; v.d = d;
        v.expAck = eAck; v.expErr = eErr; v.chkData = cData; v.expData = eData; v.expLat = eLat;
        return v;
    endfunction

    // One complete transfer: raise the request, wait (bounded) for termination,
    // drop the request and confirm the following gap cycle stays quiet.
    task automatic applyStimulus(input int idx, input logic w, input logic [3:0] s,
                                 input logic [7:0] a, input logic [31:0] d,
                                 output int lat, output logic gotAck, output logic gotErr,
                                 output logic [31:0] rd);
        @(negedge clk);
        cyc[idx] = 1'b1; stb[idx] = 1'b1; we[idx] = w;
        sel[idx] = s; addr[idx] = a; wdata[idx] = d;
        lat = 0; gotAck = 1'b0; gotErr = 1'b0; rd = '0;
        while (!gotAck && !gotErr && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ack[idx] || err[idx]) begin
                gotAck = ack[idx];
                gotErr = err[idx];
                rd     = rdata[idx];
            end
        end
        cyc[idx] = 1'b0; stb[idx] = 1'b0;
        if (!gotAck && !gotErr) begin
            checkOutput("termination timeout", 32'd0, 32'd1);
        end
        checkOutput("ack and err together", 32'(gotAck && gotErr), 32'd0);
        @(negedge clk);
        checkOutput("gap cycle ack/err", {30'd0, ack[idx], err[idx]}, 32'd0);
    endtask

    vec_t        vecs [16];
    int          lat;
    logic        gotAck;
    logic        gotErr;
    logic [31:0] rd;
    int          firstAck;
    int          secondAck;
    int          ackCount;
    int          errCount;

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = mkVec(0, 1'b0, 4'b1111, 8'h05, 32'h0,        1, 0, 1, 32'h11111111, 1);
        vecs[1]  = mkVec(0, 1'b1, 4'b0101, 8'h10, 32'hDEADBEEF, 1, 0, 0, 32'h0,        1);
        vecs[2]  = mkVec(0, 1'b0, 4'b1111, 8'h10, 32'h0,        1, 0, 1, 32'h11AD11EF, 1);
        vecs[3]  = mkVec(0, 1'b1, 4'b1111, 8'hC8, 32'h55555555, 0, 1, 0, 32'h0,        1);
        vecs[4]  = mkVec(0, 1'b0, 4'b1111, 8'hC8, 32'h0,        0, 1, 1, 32'h0,        1);
        vecs[5]  = mkVec(0, 1'b0, 4'b1111, 8'hC7, 32'h0,        1, 0, 1, 32'h11111111, 1);
        vecs[6]  = mkVec(0, 1'b1, 4'b0000, 8'h11, 32'hCAFEBABE, 1, 0, 0, 32'h0,        1);
        vecs[7]  = mkVec(0, 1'b0, 4'b1111, 8'h11, 32'h0,        1, 0, 1, 32'h11111111, 1);
        vecs[8]  = mkVec(0, 1'b1, 4'b1111, 8'h12, 32'h12345678, 1, 0, 0, 32'h0,        1);
        vecs[9]  = mkVec(0, 1'b0, 4'b1111, 8'h12, 32'h0,        1, 0, 1, 32'h12345678, 1);
        vecs[10] = mkVec(0, 1'b1, 4'b1000, 8'h12, 32'hAB000000, 1, 0, 0, 32'h0,        1);
        vecs[11] = mkVec(0, 1'b0, 4'b0000, 8'h12, 32'h0,        1, 0, 1, 32'hAB345678, 1);
        vecs[12] = mkVec(1, 1'b0, 4'b1111, 8'h05, 32'h0,        1, 0, 1, 32'h11111111, 4);
        vecs[13] = mkVec(1, 1'b1, 4'b1111, 8'hFF, 32'hA5A5A5A5, 1, 0, 0, 32'h0,        4);
        vecs[14] = mkVec(1, 1'b0, 4'b1111, 8'hFF, 32'h0,        1, 0, 1, 32'hA5A5A5A5, 4);
        vecs[15] = mkVec(2, 1'b0, 4'b1111, 8'h20, 32'h0,        1, 0, 1, 32'h11111111, 6);

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            sel[i] = '0; addr[i] = '0; wdata[i] = '0;
        end

        // Reset values on every instance.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset ack", 32'(ack[i]), 32'd0);
            checkOutput("reset err", 32'(err[i]), 32'd0);
            checkOutput("reset rdata", rdata[i], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven transfers.
        for (int v = 0; v < 16; v++) begin
            applyStimulus(vecs[v].idx, vecs[v].w, vecs[v].s, vecs[v].a, vecs[v].d,
                          lat, gotAck, gotErr, rd);
            checkOutput($sformatf("vec%0d ack", v), 32'(gotAck), 32'(vecs[v].expAck));
            checkOutput($sformatf("vec%0d err", v), 32'(gotErr), 32'(vecs[v].expErr));
            checkOutput($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].expLat));
            if (vecs[v].chkData) begin
                checkOutput($sformatf("vec%0d rdata", v), rd, vecs[v].expData);
            end
        end

        // Held strobe on the 3-wait instance: one ack per 6-cycle transfer.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; addr[1] = 8'h05;
        firstAck = -1; secondAck = -1; ackCount = 0; errCount = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ack[1]) begin
                ackCount++;
                if (firstAck < 0) firstAck = c;
                else if (secondAck < 0) secondAck = c;
            end
            if (err[1]) errCount++;
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        checkOutput("held stb first ack cycle", 32'(firstAck), 32'd4);
        checkOutput("held stb second ack cycle", 32'(secondAck), 32'd10);
        checkOutput("held stb ack count", 32'(ackCount), 32'd2);
        checkOutput("held stb err count", 32'(errCount), 32'd0);
        repeat (3) @(negedge clk);

        // Abort: cyc dropped during wait states of a write.
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF;
        addr[2] = 8'h20; wdata[2] = 32'h00000000;
        repeat (2) @(negedge clk);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        ackCount = 0; errCount = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack[2]) ackCount++;
            if (err[2]) errCount++;
        end
        checkOutput("abort ack count", 32'(ackCount), 32'd0);
        checkOutput("abort err count", 32'(errCount), 32'd0);
        applyStimulus(2, 1'b0, 4'hF, 8'h20, 32'h0, lat, gotAck, gotErr, rd);
        checkOutput("abort readback ack", 32'(gotAck), 32'd1);
        checkOutput("abort readback rdata", rd, 32'h11111111);

        // Reset asserted in the middle of a waiting write.
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF;
        addr[2] = 8'h30; wdata[2] = 32'h00000000;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset ack", 32'(ack[2]), 32'd0);
        checkOutput("mid reset err", 32'(err[2]), 32'd0);
        checkOutput("mid reset rdata", rdata[2], 32'd0);
        checkOutput("mid reset rdata dut0", rdata[0], 32'd0);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2, 1'b0, 4'hF, 8'h30, 32'h0, lat, gotAck, gotErr, rd);
        checkOutput("post reset read 0x30", rd, 32'h11111111);
        applyStimulus(0, 1'b0, 4'hF, 8'h10, 32'h0, lat, gotAck, gotErr, rd);
        checkOutput("post reset reinit 0x10", rd, 32'h11111111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
